fnd_decoder: RTL and testbench
==============================

FND_DECODER -- requirements
Module: fnd_decoder

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 16: cycles {an,seg_data} must stay unchanged after synchronization before a digit is captured; legal range 4..255.
REQ-002 SHALL provide port clk  input  1  system clock, 100 MHz.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port an  input  4  digit-select lines, active-low; 1110=ones, 1101=tens, 1011=hundreds, 0111=thousands.
REQ-005 SHALL provide port seg_data  input  8  segment pattern, common anode (0=lit), bit7=dp, bits6..0=g..a.
REQ-006 SHALL provide port data_out  output  14  last decoded value, 0..9999, binary.
REQ-007 SHALL provide port data_valid  output  1  one-cycle pulse when data_out updates.
REQ-008 SHALL provide port seg_error  output  1  one-cycle pulse when a completed frame contained an undecodable digit.

Function
REQ-009 SHALL pass an and seg_data through a 2-flop synchronizer; synchronizer flops reset to all-ones.
REQ-010 SHALL hold an 8-bit settle counter, cleared on any change of synchronized {an,seg_data} and incremented while unchanged, saturating at SETTLE_CYCLES.
REQ-011 SHALL capture one digit on the edge where the settle counter reaches SETTLE_CYCLES-1, once per stable interval; no re-capture until the next change.
REQ-012 SHALL capture only when synchronized an is exactly one of the four one-hot-low codes; 1111, 0000, or multiple-low codes SHALL capture nothing and leave state unchanged.
REQ-013 SHALL decode seg_data[6:0] ignoring dp: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9; any other pattern SHALL mark that position invalid.
REQ-014 SHALL store each captured digit and its invalid bit into a per-position register and set that position's bit in a 4-bit collected mask; a repeat capture of the same position before frame completion SHALL overwrite (latest wins).
REQ-015 SHALL treat a frame as complete on the capture edge that makes the mask 1111; on that edge it SHALL snapshot all four digits and invalid bits (including the incoming one), clear the mask, and enter CONVERT.
REQ-016 SHALL implement FSM states IDLE and CONVERT; IDLE->CONVERT on frame completion; CONVERT->IDLE after 4 steps.
REQ-017 SHALL in CONVERT compute acc = acc*10 + digit over 4 steps in the order thousands, hundreds, tens, ones, acc starting at 0, 14-bit arithmetic (max 9999, no overflow).
REQ-018 SHALL, on the 4th CONVERT edge, if no snapshot digit was invalid, load data_out with the result and assert data_valid for exactly one cycle.
REQ-019 SHALL, if any snapshot digit was invalid, leave data_out unchanged, suppress data_valid, and pulse seg_error for one cycle on the same edge.
REQ-020 SHALL continue digit capture into the collection registers while in CONVERT; snapshot isolation SHALL guarantee the running conversion is unaffected.
REQ-021 SHALL, should a frame complete while in CONVERT (impossible for legal SETTLE_CYCLES), ignore the new completion and keep its mask cleared.
REQ-022 SHALL never assert data_valid and seg_error in the same cycle.

Reset
REQ-023 SHALL on reset asynchronously force data_out=0, data_valid=0, seg_error=0, FSM=IDLE, mask=0000, settle counter=0, acc=0, all digit registers=0.
REQ-024 SHALL on reset asserted mid-CONVERT abort the conversion with no data_valid or seg_error pulse afterwards.
REQ-025 SHALL resume capture only after reset deassertion plus synchronizer and settle delay; no partial pre-reset frame survives.

Verification
REQ-026 SHALL verify: multiplexed 1234, 64 cycles per digit, ones first -> data_out=1234, one data_valid per 4-digit rotation, pulse 4 edges after the thousands capture.
REQ-027 SHALL verify: 9999 then 0000 frames -> data_out=9999 then 0, one data_valid each.
REQ-028 SHALL verify: seg_data glitch 3 cycles wide inside a digit slot, SETTLE_CYCLES=16 -> no capture of glitch value, frame decodes correctly.
REQ-029 SHALL verify: hundreds slot driven 8'hFF after a valid 1234 frame -> seg_error one-cycle pulse, data_out stays 1234, no data_valid.
REQ-030 SHALL verify: an=1111 and an=1100 slots interleaved -> no capture, mask unchanged, subsequent valid frame decodes.
REQ-031 SHALL verify: reset pulsed during CONVERT -> data_out=0, no pulses, next full frame 5678 -> data_out=5678.

Source files
------------

// File: rtl/fnd_decoder.sv
// fnd_decoder: recovers the number shown on a multiplexed 4-digit common-anode
// seven-segment display by sniffing its digit-select and segment lines.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   an[3:0]    in   digit selects, active-low (1110 ones .. 0111 thousands)
//   seg_data   in   segment pattern, 0 = lit, bit7 = dp, bits6..0 = g..a
//   data_out   out  last successfully decoded value, 0..9999
//   data_valid out  one-cycle pulse when data_out updates
//   seg_error  out  one-cycle pulse when a completed frame held a bad digit
module fnd_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  seg_data,
    output logic [13:0] data_out,
    output logic        data_valid,
    output logic        seg_error
);

    typedef enum logic {StIdle, StConvert} state_e;

    localparam logic [7:0] SettleMax = 8'(SETTLE_CYCLES);
    // Count value one edge before the counter reaches SETTLE_CYCLES-1.
    localparam logic [7:0] CaptureFrom = 8'(SETTLE_CYCLES - 2);

    // Synchronizer plus one delayed copy for change detection.
    logic [11:0] sync1_q, sync2_q, prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {an, seg_data};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign stable = (sync2_q == prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q != SettleMax) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Digit position from the synchronized selects; anything not one-hot-low is ignored.
    logic [3:0] an_s;
    logic [6:0] seg_s;
    logic       pos_valid;
    logic [1:0] pos_idx;

    assign an_s  = sync2_q[11:8];
    assign seg_s = sync2_q[6:0];

    always_comb begin
        pos_valid = 1'b1;
        pos_idx   = 2'd0;
        case (an_s)
            4'b1110: pos_idx = 2'd0;
            4'b1101: pos_idx = 2'd1;
            4'b1011: pos_idx = 2'd2;
            4'b0111: pos_idx = 2'd3;
            default: pos_valid = 1'b0;
        endcase
    end

    // Segment decode, dp ignored.
    logic [3:0] dec_val;
    logic       dec_inv;

    always_comb begin
        dec_val = 4'd0;
        dec_inv = 1'b0;
        case (seg_s)
            7'h40:   dec_val = 4'd0;
            7'h79:   dec_val = 4'd1;
            7'h24:   dec_val = 4'd2;
            7'h30:   dec_val = 4'd3;
            7'h19:   dec_val = 4'd4;
            7'h12:   dec_val = 4'd5;
            7'h02:   dec_val = 4'd6;
            7'h78:   dec_val = 4'd7;
            7'h00:   dec_val = 4'd8;
            7'h10:   dec_val = 4'd9;
            default: dec_inv = 1'b1;
        endcase
    end

    logic capture;
    assign capture = stable && (cnt_q == CaptureFrom) && pos_valid;

    // Collection registers: digits packed 4 bits per position, ones at [3:0].
    logic [15:0] digits_q, digits_d;
    logic [3:0]  inv_q, inv_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  mask_set;
    logic        frame_done;

    assign mask_set   = mask_q | (4'b0001 << pos_idx);
    assign frame_done = capture && (mask_set == 4'b1111);

    always_comb begin
        digits_d = digits_q;
        inv_d    = inv_q;
        mask_d   = mask_q;
        if (capture) begin
            digits_d[{pos_idx, 2'b00} +: 4] = dec_val;
            inv_d[pos_idx]                  = dec_inv;
            // A completion always clears the mask, even if CONVERT ignores it.
            mask_d = (mask_set == 4'b1111) ? 4'b0000 : mask_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q <= '0;
            inv_q    <= '0;
            mask_q   <= '0;
        end else begin
            digits_q <= digits_d;
            inv_q    <= inv_d;
            mask_q   <= mask_d;
        end
    end

    // Conversion FSM working on a snapshot so new captures cannot disturb it.
    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [13:0] acc_q, acc_d, acc_next;
    logic [15:0] snap_q, snap_d;
    logic [3:0]  snap_inv_q, snap_inv_d;
    logic [13:0] data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [1:0]  sel;
    logic [3:0]  cur_digit;
    logic        converting;

    assign converting = (state_q == StConvert);
    // Step 0 takes thousands (position 3), step 3 takes ones.
    assign sel       = ~step_q;
    assign cur_digit = snap_q[{sel, 2'b00} +: 4];
    assign acc_next  = acc_q * 14'd10 + {10'd0, cur_digit};

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        acc_d      = acc_q;
        snap_d     = snap_q;
        snap_inv_d = snap_inv_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (frame_done) begin
                    snap_d     = digits_d;
                    snap_inv_d = inv_d;
                    acc_d      = '0;
                    step_d     = 2'd0;
                    state_d    = StConvert;
                end
            end
            StConvert: begin
                acc_d  = acc_next;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = StIdle;
                    if (|snap_inv_q) begin
                        err_d = 1'b1;
                    end else begin
                        data_out_d = acc_next;
                        valid_d    = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            step_q     <= '0;
            acc_q      <= '0;
            snap_q     <= '0;
            snap_inv_q <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            snap_q     <= snap_d;
            snap_inv_q <= snap_inv_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign seg_error  = err_q;

endmodule

// File: tb/tb_fnd_decoder.sv
module tb_fnd_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [7:0]  seg_data;
    logic [13:0] data_out;
    logic        data_valid;
    logic        seg_error;

    fnd_decoder #(.SETTLE_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .seg_data   (seg_data),
        .data_out   (data_out),
        .data_valid (data_valid),
        .seg_error  (seg_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit          is_err;
        logic [13:0] value;
    } exp_t;
    exp_t exp_q[$];

    int thous_cyc = 0;
    bit lat_arm   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input bit is_err, input int v);
        exp_t e;
        e.is_err = is_err;
        e.value  = 14'(v);
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    task automatic slot(input logic [3:0] a, input logic [7:0] s, input int n);
        an       = a;
        seg_data = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ones first, 64 cycles per digit; thousands completes the frame.
    task automatic frame(input int v, input bit arm);
        slot(4'b1110, seg_of(v % 10), 64);
        slot(4'b1101, seg_of((v / 10) % 10), 64);
        slot(4'b1011, seg_of((v / 100) % 10), 64);
        if (arm) begin
            thous_cyc = cyc;
            lat_arm   = 1'b1;
        end
        slot(4'b0111, seg_of((v / 1000) % 10), 64);
    endtask

    // Scoreboard: every pulse must match the oldest pending expectation.
    logic dv_prev = 1'b0;
    logic se_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            dv_prev <= 1'b0;
            se_prev <= 1'b0;
        end else begin
            if (data_valid || seg_error) begin
                chk("exclusive_pulses", 32'(data_valid & seg_error), 0);
                chk("one_cycle_pulse", 32'(dv_prev | se_prev), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind_err", 32'(seg_error), 32'(e.is_err));
                    chk("pulse_data_out", 32'(data_out), 32'(e.value));
                    if (lat_arm) begin
                        // 2 sync + change detect + 15 settle edges to capture, then 4 CONVERT edges.
                        chk("latency_window", 32'((cyc - thous_cyc) inside {[20:24]}), 1);
                        lat_arm = 1'b0;
                    end
                end
            end
            dv_prev <= data_valid;
            se_prev <= seg_error;
        end
    end

    initial begin
        bit reached;
        an       = 4'hF;
        seg_data = 8'hFF;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", 32'(data_out), 0);
        chk("reset_valid", 32'(data_valid), 0);
        chk("reset_err", 32'(seg_error), 0);
        reset = 1'b0;
        slot(4'hF, 8'hFF, 10);

        // 1234, two rotations, one pulse each.
        push(1'b0, 1234);
        frame(1234, 1'b1);
        chk("f1234_data_out", 32'(data_out), 1234);
        chk("f1234_drained", 32'(exp_q.size()), 0);
        push(1'b0, 1234);
        frame(1234, 1'b0);
        chk("f1234b_drained", 32'(exp_q.size()), 0);

        // 9999 then 0000.
        push(1'b0, 9999);
        frame(9999, 1'b0);
        chk("f9999_data_out", 32'(data_out), 9999);
        push(1'b0, 0);
        frame(0, 1'b0);
        chk("f0000_data_out", 32'(data_out), 0);
        chk("f0000_drained", 32'(exp_q.size()), 0);

        // 3-cycle glitches: mid tens slot and at the tail of the hundreds slot.
        push(1'b0, 4321);
        slot(4'b1110, seg_of(1), 64);
        slot(4'b1101, seg_of(2), 20);
        slot(4'b1101, seg_of(8), 3);
        slot(4'b1101, seg_of(2), 41);
        slot(4'b1011, seg_of(3), 61);
        slot(4'b1011, seg_of(8), 3);
        slot(4'b0111, seg_of(4), 64);
        chk("glitch_data_out", 32'(data_out), 4321);
        chk("glitch_drained", 32'(exp_q.size()), 0);

        // Bad hundreds digit after a good 1234.
        push(1'b0, 1234);
        frame(1234, 1'b0);
        push(1'b1, 1234);
        slot(4'b1110, seg_of(4), 64);
        slot(4'b1101, seg_of(3), 64);
        slot(4'b1011, 8'hFF, 64);
        slot(4'b0111, seg_of(1), 64);
        chk("segerr_data_out", 32'(data_out), 1234);
        chk("segerr_drained", 32'(exp_q.size()), 0);

        // Illegal selects interleaved mid-frame.
        push(1'b0, 8765);
        slot(4'b1110, seg_of(5), 64);
        slot(4'b1101, seg_of(6), 64);
        slot(4'b1111, seg_of(9), 64);
        slot(4'b1100, seg_of(9), 64);
        chk("illegal_an_mask", 32'(dut.mask_q), 32'h3);
        slot(4'b1011, seg_of(7), 64);
        slot(4'b0111, seg_of(8), 64);
        chk("illegal_an_data_out", 32'(data_out), 8765);
        chk("illegal_an_drained", 32'(exp_q.size()), 0);

        // Reset during CONVERT aborts the conversion.
        slot(4'b1110, seg_of(1), 64);
        slot(4'b1101, seg_of(2), 64);
        slot(4'b1011, seg_of(3), 64);
        an       = 4'b0111;
        seg_data = seg_of(4);
        reached  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (dut.converting) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reached_convert", 32'(reached), 1);
        reset    = 1'b1;
        an       = 4'hF;
        seg_data = 8'hFF;
        #1;
        chk("midcvt_reset_data_out", 32'(data_out), 0);
        chk("midcvt_reset_valid", 32'(data_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midcvt_reset_idle", 32'(dut.converting), 0);
        reset = 1'b0;
        slot(4'hF, 8'hFF, 40);
        chk("post_reset_data_out", 32'(data_out), 0);
        chk("post_reset_no_pulse", 32'(exp_q.size()), 0);
        push(1'b0, 5678);
        frame(5678, 1'b0);
        chk("f5678_data_out", 32'(data_out), 5678);

        slot(4'hF, 8'hFF, 20);
        chk("final_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
